seven_seg_axi_slave: RTL and testbench
======================================

# seven_seg_axi_slave

AXI4-Lite slave register file for the seven-segment display IP. It accepts single-beat writes and reads from the block-design AXI master on the S00_AXI port. It holds four 32-bit read/write registers that feed the display core. It also emits one-cycle write pulses so the core can react to register updates.

## Interface

Parameters:
- C_S00_AXI_DATA_WIDTH, 32: data bus width; only 32 supported.
- C_S00_AXI_ADDR_WIDTH, 4: byte address width; decodes 4 word registers at 0x0, 0x4, 0x8, 0xC.

Ports:
- s00_axi_aclk  in  1  sole clock; all logic rising-edge.
- s00_axi_reset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  4  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables; bit k enables wdata[8k+7:8k].
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  always 2'b00 (OKAY).
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  4  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  always 2'b00.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- slv_reg0..slv_reg3  out  32 each  current register contents to the display core.
- reg_wr_pulse  out  4  bit i high one cycle after register i is written.

## Operation

- Word index is addr[3:2]; addr[1:0] ignored. All four indices are valid, so there is no error response.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready=1 until an AW is captured; wready=1 until a W is captured. AW and W are captured independently, in either order or in the same cycle.
  - On the edge where both are held (captured earlier or handshaking now), register[idx] bytes with wstrb=1 take wdata; bytes with wstrb=0 are unchanged. On that edge reg_wr_pulse[idx] is set, bvalid is set, and the FSM moves to W_RESP.
  - W_RESP: awready=wready=0. bvalid is held until bready=1. On the bvalid&&bready edge the FSM returns to W_IDLE and clears the captured AW and W.
  - wstrb=4'b0000 is still a full transaction: response issued, register unchanged, pulse still fires.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the arvalid edge, rdata takes register[araddr[3:2]] (pre-edge value), rvalid is set, and the FSM moves to R_DATA.
  - R_DATA: arready=0. rdata and rvalid are held stable until rready. On rvalid&&rready the FSM returns to R_IDLE.
- Read and write paths are independent and may be active in the same cycle.
- Same-edge write commit and AR handshake to the same register: the read returns the old value.
- At most one outstanding write and one outstanding read.

## Timing

- Reset (sampled high at an edge) values:
  - registers 0;
  - bvalid, rvalid, reg_wr_pulse 0;
  - rdata 0;
  - FSMs at IDLE with no held AW or W;
  - awready, wready, arready forced 0 while reset is high, then 1 in the first cycle after reset falls.
- Reset mid-transaction: pending captures are discarded; bvalid and rvalid drop at that edge.
- Write latency: the commit edge is the edge of the later of the AW/W handshakes. bvalid and the new slv_regN value are visible in the cycle after it. Minimum AW/W-to-B is 1 cycle.
- Back-to-back writes: the next AW/W can be accepted in the cycle after the B handshake, giving a minimum 2-cycle write throughput.
- Read latency: rvalid is visible in the cycle after the AR handshake. Minimum read throughput is 2 cycles.
- reg_wr_pulse is exactly one cycle wide.
- ready outputs are combinational from state registers and reset only, never from valid inputs.

## Test plan

- Sequential R/W: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with wstrb=0xF, then read all four. Expected: reads return 1, 2, 3, 4; bresp and rresp are 00; reg_wr_pulse fires 0001, 0010, 0100, 1000 in order.
- Channel ordering: W 0xDEADBEEF presented 3 cycles before AW 0x8. Expected: wready drops after its handshake; commit on the AW edge; slv_reg2=0xDEADBEEF; bvalid the following cycle. Repeat with AW first.
- Byte strobes: reg1=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101. Expected: reg1=0x11BB33DD.
- Backpressure: hold bready=0 for 5 cycles and rready=0 for 5 cycles. Expected: bvalid, rvalid and rdata stay stable; awready, wready, arready stay 0 until each handshake completes.
- Collision: reg3=0x5, then a write of 0x9 to 0xC commits on the same edge as an AR to 0xC. Expected: read returns 0x5; a subsequent read returns 0x9.
- Reset mid-op: assert reset while bvalid=1 and rvalid=1. Expected: both drop at that edge; all slv_reg read 0; readies return to 1 one cycle after reset deasserts.

Source files
------------

// File: rtl/seven_seg_axi_slave.sv
// rtl/seven_seg_axi_slave.sv - AXI4-Lite register file feeding the seven-segment display core
//
// Four 32-bit read/write registers at word offsets 0x0, 0x4, 0x8, 0xC.
// Ports:
//   s00_axi_aclk / s00_axi_reset      clock, synchronous active-high reset
//   s00_axi_aw* / s00_axi_w* / s00_axi_b*   AXI4-Lite write channels
//   s00_axi_ar* / s00_axi_r*          AXI4-Lite read channels
//   slv_reg0..slv_reg3                current register contents
//   reg_wr_pulse                      one-cycle pulse per register on write commit
module seven_seg_axi_slave #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_reset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     slv_reg0,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     slv_reg1,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     slv_reg2,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     slv_reg3,
    output logic [3:0]                          reg_wr_pulse
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int NB = C_S00_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    // AW and W are captured independently; these hold whichever arrived first
    logic          aw_held;
    logic          w_held;
    logic [1:0]    aw_idx_q;
    logic [DW-1:0] wdata_q;
    logic [NB-1:0] wstrb_q;

    logic [DW-1:0] regs [4];

    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          commit;
    logic [1:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_strb;

    // Address low bits and protection fields carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Readies depend only on state and reset so they never loop back on valid
    assign s00_axi_awready = !s00_axi_reset && (w_state == W_IDLE) && !aw_held;
    assign s00_axi_wready  = !s00_axi_reset && (w_state == W_IDLE) && !w_held;
    assign s00_axi_arready = !s00_axi_reset && (r_state == R_IDLE);

    assign s00_axi_bvalid = (w_state == W_RESP);
    assign s00_axi_rvalid = (r_state == R_DATA);
    assign s00_axi_bresp  = 2'b00;
    assign s00_axi_rresp  = 2'b00;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
    assign b_hs  = s00_axi_bvalid  && s00_axi_bready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;
    assign r_hs  = s00_axi_rvalid  && s00_axi_rready;

    // Commit uses the captured copy if present, otherwise the live bus
    assign wr_idx  = aw_held ? aw_idx_q : s00_axi_awaddr[3:2];
    assign wr_data = w_held  ? wdata_q  : s00_axi_wdata;
    assign wr_strb = w_held  ? wstrb_q  : s00_axi_wstrb;

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        commit       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (s00_axi_arvalid) begin
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            reg_wr_pulse <= '0;
            s00_axi_rdata <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr_pulse <= '0;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (commit) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_strb[k]) begin
                        regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
                reg_wr_pulse[wr_idx] <= 1'b1;
            end
            // Captures are released only once the response is accepted
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            // Non-blocking read of regs gives the pre-commit value on a collision
            if (ar_hs) begin
                s00_axi_rdata <= regs[s00_axi_araddr[3:2]];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_axi_slave.sv
// tb/tb_seven_seg_axi_slave.sv - randomized self-checking bench for seven_seg_axi_slave
module tb_seven_seg_axi_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic [3:0]  reg_wr_pulse;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [4];

    always #5 clk = ~clk;

    seven_seg_axi_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_reset   (reset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .slv_reg0        (slv_reg0),
        .slv_reg1        (slv_reg1),
        .slv_reg2        (slv_reg2),
        .slv_reg3        (slv_reg3),
        .reg_wr_pulse    (reg_wr_pulse)
    );

    function automatic logic [31:0] dut_reg(input int i);
        case (i)
            0:       return slv_reg0;
            1:       return slv_reg1;
            2:       return slv_reg2;
            default: return slv_reg3;
        endcase
    endfunction

    // One write transaction. Delays are in cycles from the task start; b_dly
    // is how many cycles bvalid is left waiting before bready is raised.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly,
                            input int w_dly, input int b_dly);
        int cyc;
        int bcnt;
        int idx;
        bit aw_done, w_done, b_done, committed, aw_hs, w_hs;
        cyc = 0; bcnt = 0; idx = int'(addr[3:2]);
        aw_done = 0; w_done = 0; b_done = 0; committed = 0;
        while (!b_done && cyc < 200) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            bready  = bvalid && bcnt >= b_dly;
            #1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (!committed) begin
                vectors++;
                if (awready !== !aw_done || wready !== !w_done) begin
                    miscompares++;
                    $display("FAIL wr_ready_idle awready=%b wready=%b exp %b %b",
                             awready, wready, !aw_done, !w_done);
                end
            end else begin
                vectors++;
                if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00) begin
                    miscompares++;
                    $display("FAIL wr_resp_hold awready=%b wready=%b bvalid=%b bresp=%b exp 0 0 1 00",
                             awready, wready, bvalid, bresp);
                end
            end
            if (bvalid && bready) b_done = 1;
            if (bvalid) bcnt++;
            @(posedge clk); #1;
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            if (!committed && aw_done && w_done) begin
                committed = 1;
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
                vectors++;
                if (bvalid !== 1'b1 || reg_wr_pulse !== (4'b0001 << idx) || dut_reg(idx) !== model[idx]) begin
                    miscompares++;
                    $display("FAIL wr_commit bvalid=%b pulse=%b reg%0d=%h exp 1 %b %h",
                             bvalid, reg_wr_pulse, idx, dut_reg(idx), 4'b0001 << idx, model[idx]);
                end
            end else begin
                vectors++;
                if (reg_wr_pulse !== 4'b0000 || (!committed && bvalid !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL wr_quiet pulse=%b bvalid=%b exp 0000 (bvalid 0 before commit)",
                             reg_wr_pulse, bvalid);
                end
            end
            cyc++;
        end
        vectors++;
        if (!b_done || bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done b_done=%b bvalid=%b exp 1 0", b_done, bvalid);
        end
        awvalid = 0; wvalid = 0; bready = 0;
    endtask

    // One read transaction; the expected word is taken from the model just
    // before the AR handshake edge so a same-edge write is not yet visible.
    task automatic do_read(input logic [3:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] got);
        int cyc;
        int rcnt;
        bit ar_done, r_done, hs;
        logic [31:0] exp_d, held;
        cyc = 0; rcnt = 0; ar_done = 0; r_done = 0; got = '0; exp_d = '0; held = '0;
        while (!r_done && cyc < 200) begin
            araddr  = addr;
            arvalid = !ar_done && cyc >= ar_dly;
            rready  = rvalid && rcnt >= r_dly;
            #1;
            hs = arvalid && arready;
            if (hs) exp_d = model[addr[3:2]];
            if (!ar_done) begin
                vectors++;
                if (arready !== 1'b1 || rvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rd_idle arready=%b rvalid=%b exp 1 0", arready, rvalid);
                end
            end
            if (rvalid) begin
                vectors++;
                if (arready !== 1'b0 || rresp !== 2'b00 || rdata !== held) begin
                    miscompares++;
                    $display("FAIL rd_hold arready=%b rresp=%b rdata=%h exp 0 00 %h",
                             arready, rresp, rdata, held);
                end
                if (rready) begin
                    r_done = 1;
                    got = rdata;
                end
                rcnt++;
            end
            @(posedge clk); #1;
            if (hs) begin
                ar_done = 1;
                held = exp_d;
                vectors++;
                if (rvalid !== 1'b1 || rdata !== exp_d) begin
                    miscompares++;
                    $display("FAIL rd_data rvalid=%b rdata=%h exp 1 %h", rvalid, rdata, exp_d);
                end
            end
            cyc++;
        end
        vectors++;
        if (!r_done || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_done r_done=%b rvalid=%b exp 1 0", r_done, rvalid);
        end
        arvalid = 0; rready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({slv_reg0, slv_reg1, slv_reg2, slv_reg3} !== 128'd0 || bvalid !== 0 || rvalid !== 0 ||
            reg_wr_pulse !== 4'd0 || rdata !== 32'd0 || {awready, wready, arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state regs=%h %h %h %h bv=%b rv=%b pulse=%b rdata=%h rdy=%b%b%b exp all 0",
                     slv_reg0, slv_reg1, slv_reg2, slv_reg3, bvalid, rvalid, reg_wr_pulse, rdata,
                     awready, wready, arready);
        end
        reset = 0;
        @(posedge clk); #1;
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_release rdy=%b%b%b exp 111", awready, wready, arready);
        end
        for (int i = 0; i < 4; i++) model[i] = '0;
    endtask

    task automatic test_sequential();
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), 0, 0, rd);
            vectors++;
            if (rd !== 32'(i + 1)) begin
                miscompares++;
                $display("FAIL seq_read idx=%0d got=%h exp=%h", i, rd, i + 1);
            end
        end
    endtask

    task automatic test_channel_order();
        do_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        vectors++;
        if (slv_reg2 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL w_first reg2=%h exp deadbeef", slv_reg2);
        end
        do_write(4'h8, 32'hCAFEF00D, 4'hF, 0, 3, 0);
        vectors++;
        if (slv_reg2 !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL aw_first reg2=%h exp cafef00d", slv_reg2);
        end
    endtask

    task automatic test_strobes();
        do_write(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(4'h5, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        vectors++;
        if (slv_reg1 !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL strobe reg1=%h exp 11bb33dd", slv_reg1);
        end
        do_write(4'h4, 32'hFFFFFFFF, 4'b0000, 1, 0, 1);
        vectors++;
        if (slv_reg1 !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL strobe_none reg1=%h exp 11bb33dd", slv_reg1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        fork
            do_write(4'h0, 32'h0BADF00D, 4'hF, 0, 1, 5);
            do_read(4'hC, 0, 5, rd);
        join
        vectors++;
        if (rd !== model[3]) begin
            miscompares++;
            $display("FAIL bp_read got=%h exp=%h", rd, model[3]);
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        do_write(4'hC, 32'h5, 4'hF, 0, 0, 0);
        fork
            do_write(4'hC, 32'h9, 4'hF, 0, 0, 0);
            do_read(4'hC, 0, 0, rd);
        join
        vectors++;
        if (rd !== 32'h5) begin
            miscompares++;
            $display("FAIL collide_old got=%h exp 5", rd);
        end
        do_read(4'hC, 0, 0, rd);
        vectors++;
        if (rd !== 32'h9) begin
            miscompares++;
            $display("FAIL collide_new got=%h exp 9", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rd);
                default: fork
                    do_write(4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 3));
                    do_read(4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rd);
                join
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_reg(i) !== model[i]) begin
                miscompares++;
                $display("FAIL rand_final reg%0d=%h exp=%h", i, dut_reg(i), model[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        awaddr = 4'h4; wdata = 32'h12345678; wstrb = 4'hF; araddr = 4'h4;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        vectors++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_setup bvalid=%b rvalid=%b exp 1 1", bvalid, rvalid);
        end
        reset = 1;
        @(posedge clk); #1;
        vectors++;
        if (bvalid !== 0 || rvalid !== 0 || {awready, wready, arready} !== 3'b000 ||
            {slv_reg0, slv_reg1, slv_reg2, slv_reg3} !== 128'd0) begin
            miscompares++;
            $display("FAIL midop_reset bv=%b rv=%b rdy=%b%b%b regs=%h %h %h %h exp 0 0 000 all 0",
                     bvalid, rvalid, awready, wready, arready, slv_reg0, slv_reg1, slv_reg2, slv_reg3);
        end
        reset = 0;
        @(posedge clk); #1;
        vectors++;
        if ({awready, wready, arready} !== 3'b111 || bvalid !== 0 || rvalid !== 0) begin
            miscompares++;
            $display("FAIL midop_release rdy=%b%b%b bv=%b rv=%b exp 111 0 0",
                     awready, wready, arready, bvalid, rvalid);
        end
        for (int i = 0; i < 4; i++) model[i] = '0;
    endtask

    initial begin
        reset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        test_reset();
        test_sequential();
        test_channel_order();
        test_strobes();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
